// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and frame constants.
package uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_e;

   // Parity mismatch test for a received data byte and its parity bit.
   function automatic logic parity_bad(
      input logic [UART_DATA_BITS-1:0] data,
      input logic                      pbit,
      input logic                      odd
   );
      return ((^data) ^ pbit) != odd;
   endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous serial line, idling high.
module uart_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '1;
      end else begin
         sync_q[0] <= d_i;
         for (int i = 1; i < STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: mid-bit sampling of 8N1/8P1 frames with a valid/ready
// output register and one-cycle framing, parity and overrun pulses.
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int DIV_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             rx_en_i,
   input  logic [DIV_W-1:0] clks_per_bit_i,
   input  logic             parity_en_i,
   input  logic             parity_odd_i,
   input  logic             rx_i,
   input  logic             rx_ready_i,
   output logic [7:0]       rx_data_o,
   output logic             rx_valid_o,
   output logic             rx_start_o,
   output logic             frame_err_o,
   output logic             parity_err_o,
   output logic             overrun_o
);

   localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);
   localparam logic [DIV_W-1:0] ONE      = DIV_W'(1);
   localparam logic [DIV_W-1:0] MIN_CPB  = DIV_W'(2);

   logic                      rxs;
   logic                      rxs_q;
   rx_state_e                 state_q;
   logic [DIV_W-1:0]          cpb_q;
   logic [DIV_W-1:0]          cnt_q;
   logic [2:0]                bit_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic                      pbit_q;
   logic                      par_seen_q;

   logic [DIV_W-1:0]          cpb_eff;
   logic [DIV_W-1:0]          half_m1;
   logic                      start_edge;
   logic                      sample;
   logic                      can_load;

   uart_sync #(
      .STAGES(SYNC_STAGES)
   ) u_sync (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .d_i   (rx_i),
      .q_o   (rxs)
   );

   // A divisor below 2 would leave no room for a half-bit offset.
   assign cpb_eff    = (clks_per_bit_i < MIN_CPB) ? MIN_CPB : clks_per_bit_i;
   assign half_m1    = (cpb_q >> 1) - ONE;
   assign start_edge = rxs_q & ~rxs;
   assign can_load   = ~rx_valid_o | rx_ready_i;

   always_comb begin
      sample = 1'b0;
      unique case (1'b1)
         state_q == ST_START: sample = (cnt_q == half_m1);
         state_q == ST_DATA,
         state_q == ST_PARITY,
         state_q == ST_STOP:  sample = (cnt_q == cpb_q - ONE);
         default:             sample = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         rxs_q        <= 1'b1;
         cpb_q        <= '0;
         cnt_q        <= '0;
         bit_q        <= '0;
         shift_q      <= '0;
         pbit_q       <= 1'b0;
         par_seen_q   <= 1'b0;
         rx_data_o    <= '0;
         rx_valid_o   <= 1'b0;
         rx_start_o   <= 1'b0;
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         overrun_o    <= 1'b0;
      end else begin
         rxs_q        <= rxs;
         frame_err_o  <= 1'b0;
         parity_err_o <= 1'b0;
         overrun_o    <= 1'b0;

         if (rx_valid_o && rx_ready_i) begin
            rx_valid_o <= 1'b0;
         end

         if (!rx_en_i) begin
            state_q    <= ST_IDLE;
            rx_start_o <= 1'b0;
            cnt_q      <= '0;
            bit_q      <= '0;
         end else begin
            unique case (state_q)
               ST_IDLE: begin
                  if (start_edge) begin
                     state_q    <= ST_START;
                     cpb_q      <= cpb_eff;
                     cnt_q      <= '0;
                     bit_q      <= '0;
                     par_seen_q <= 1'b0;
                     rx_start_o <= 1'b1;
                  end
               end

               ST_START: begin
                  if (sample) begin
                     cnt_q <= '0;
                     if (rxs) begin
                        state_q    <= ST_IDLE;
                        rx_start_o <= 1'b0;
                     end else begin
                        state_q <= ST_DATA;
                     end
                  end else begin
                     cnt_q <= cnt_q + ONE;
                  end
               end

               ST_DATA: begin
                  if (sample) begin
                     cnt_q   <= '0;
                     shift_q <= {rxs, shift_q[UART_DATA_BITS-1:1]};
                     bit_q   <= bit_q + 3'd1;
                     if (bit_q == LAST_BIT) begin
                        state_q <= parity_en_i ? ST_PARITY : ST_STOP;
                     end
                  end else begin
                     cnt_q <= cnt_q + ONE;
                  end
               end

               ST_PARITY: begin
                  if (sample) begin
                     cnt_q      <= '0;
                     pbit_q     <= rxs;
                     par_seen_q <= 1'b1;
                     state_q    <= ST_STOP;
                  end else begin
                     cnt_q <= cnt_q + ONE;
                  end
               end

               ST_STOP: begin
                  if (sample) begin
                     cnt_q        <= '0;
                     state_q      <= ST_IDLE;
                     rx_start_o   <= 1'b0;
                     frame_err_o  <= ~rxs;
                     parity_err_o <= par_seen_q &
                                     parity_bad(shift_q, pbit_q, parity_odd_i);
                     // Errored bytes are still delivered; only a full
                     // output register drops the byte.
                     if (can_load) begin
                        rx_data_o  <= shift_q;
                        rx_valid_o <= 1'b1;
                     end else begin
                        overrun_o <= 1'b1;
                     end
                  end else begin
                     cnt_q <= cnt_q + ONE;
                  end
               end

               default: begin
                  state_q    <= ST_IDLE;
                  rx_start_o <= 1'b0;
                  cnt_q      <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 SHALL have parameter DIV_W, default 16, width of the clocks-per-bit divisor.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of rx_i synchroniser flops.
REQ-003 SHALL have port clk_i, input, 1, system clock.
REQ-004 SHALL have port rst_ni, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port rx_en_i, input, 1, receiver enable.
REQ-006 SHALL have port clks_per_bit_i, input, DIV_W, clk_i cycles per bit period.
REQ-007 SHALL have port parity_en_i, input, 1, a parity bit follows the data bits.
REQ-008 SHALL have port parity_odd_i, input, 1, 1 selects odd parity, 0 selects even.
REQ-009 SHALL have port rx_i, input, 1, asynchronous serial line, idle high.
REQ-010 SHALL have port rx_ready_i, input, 1, consumer accepts rx_data_o.
REQ-011 SHALL have port rx_data_o, output, 8, received byte.
REQ-012 SHALL have port rx_valid_o, output, 1, rx_data_o valid until accepted.
REQ-013 SHALL have port rx_start_o, output, 1, frame in progress; drives the RX timeout timer's rx_start_i.
REQ-014 SHALL have port frame_err_o, output, 1, one-cycle pulse when the stop bit is sampled low.
REQ-015 SHALL have port parity_err_o, output, 1, one-cycle pulse on parity mismatch.
REQ-016 SHALL have port overrun_o, output, 1, one-cycle pulse when a completed byte is dropped.

Function
REQ-017 SHALL pass rx_i through SYNC_STAGES flops (reset value 1); "rxs" is the last stage; all sampling uses rxs.
REQ-018 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL latch cpb = max(clks_per_bit_i, 2) on leaving IDLE; mid-frame changes have no effect until the next frame.
REQ-020 IDLE -> START SHALL occur when rx_en_i=1 and rxs=1->0 between consecutive cycles (cycle T).
REQ-021 START SHALL sample rxs at T+(cpb>>1): 0 -> DATA; 1 -> IDLE with no outputs (glitch reject).
REQ-022 DATA SHALL sample data bit n (n=0..7, LSB first) at T+(cpb>>1)+(n+1)*cpb.
REQ-023 After bit 7, SHALL go to PARITY if parity_en_i=1 (one sample, cpb later), else to STOP.
REQ-024 Parity error condition: XOR(data, parity bit) != parity_odd_i.
REQ-025 STOP SHALL sample the stop bit one cpb after the last data/parity sample, then return to IDLE.
REQ-026 rx_start_o SHALL be 1 in START, DATA, PARITY and STOP, else 0.
REQ-027 On the cycle after the stop sample: if rx_valid_o=0, or rx_valid_o=1 with rx_ready_i=1, rx_data_o SHALL load the byte and rx_valid_o=1.
REQ-028 In that cycle, frame_err_o and parity_err_o SHALL pulse if their conditions hold.
REQ-029 A byte with a framing error SHALL still be delivered.
REQ-030 If rx_valid_o=1 and rx_ready_i=0 in that cycle, the new byte SHALL be dropped, rx_data_o held, overrun_o pulsed, and error pulses still issued.
REQ-031 rx_valid_o SHALL clear the cycle after rx_valid_o & rx_ready_i, unless a new byte loads in the same cycle.
REQ-032 rx_en_i=0 in any state SHALL return the FSM to IDLE next cycle, with no valid or error pulse; a held rx_valid_o is kept.
REQ-033 The bit counter SHALL be 3 bits; the cycle counter SHALL be DIV_W bits and reload 0 on every sample.
REQ-034 A new start edge SHALL be recognised only in IDLE, the earliest being the cycle after the stop sample.

Reset
REQ-035 Reset SHALL set: FSM to IDLE, synchroniser flops to 1, counters to 0, rx_data_o=0x00, rx_valid_o=0, rx_start_o=0, frame_err_o=0, parity_err_o=0, overrun_o=0.
REQ-036 Reset asserted mid-frame SHALL discard the partial byte; after release, the first byte SHALL need a fresh start edge.

Structure
REQ-037 The state enum and the UART_DATA_BITS=8 constant SHALL live in the shared uart package, uart_pkg.
REQ-038 The synchroniser SHALL be the sub-module uart_sync; all other logic SHALL be flat in uart_rx_core.

Verification
REQ-039 Scenario cpb=16, no parity, frame for 0xA5 -> rx_data_o=0xA5 with rx_valid_o rising exactly T+8+144+1.
REQ-040 Scenario rx_i low for 4 cycles with cpb=16 -> rx_start_o falls at T+8; no rx_valid_o, no error pulse.
REQ-041 Scenario 0x3C with stop bit 0 -> rx_valid_o=1, rx_data_o=0x3C, frame_err_o pulsed for 1 cycle.
REQ-042 Scenario parity_en_i=1, parity_odd_i=1, 0x01 with parity bit 1 -> parity_err_o pulses; with parity bit 0 -> no pulse.
REQ-043 Scenario 0x11 then 0x22 with rx_ready_i=0 -> rx_data_o stays 0x11 and overrun_o pulses once.
REQ-044 Scenario rx_en_i=0 during bit 3, and rst_ni=0 during bit 5 -> both return rx_start_o to 0 with no valid; the next full frame is received correctly.
